// File: rtl/yacc_superblock_tag_ctrl.sv
// Superblock tag store and replacement controller for the YACC compressed cache.
// Each request is handled in three steps: accept, look up and update, then hold the response.
module yacc_superblock_tag_ctrl #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 6,
    parameter int SUB_W  = 2,
    parameter int IDX_W  = 3,
    parameter int WAYS   = 4,
    parameter int CNT_W  = 3,
    localparam int SUBS  = 2 ** SUB_W,
    localparam int SETS  = 2 ** IDX_W,
    localparam int WAY_W = $clog2(WAYS),
    localparam int TAG_W = ADDR_W - IDX_W - SUB_W - OFF_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [1:0]        mode,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic              resp_sub_miss,
    output logic [WAY_W-1:0]  resp_way,
    output logic              resp_evict,
    output logic [TAG_W-1:0]  resp_evict_tag,
    output logic [SUBS-1:0]   resp_evict_mask
);
    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_e;
    typedef enum logic [1:0] {M_LRU, M_LFU, M_LFU_LRU, M_LRU_ALT} mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e state_q, state_d;
    mode_e  mode_q;
    logic [ADDR_W-1:0] addr_q;

    logic [SUBS-1:0]  mask_q [SETS][WAYS];
    logic [TAG_W-1:0] tag_q  [SETS][WAYS];
    logic [CNT_W-1:0] cnt_q  [SETS][WAYS];
    logic [WAY_W-1:0] age_q  [SETS][WAYS];

    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic [SUB_W-1:0] a_sub;
    logic [SUBS-1:0]  sub_oh;

    assign a_tag  = addr_q[ADDR_W-1 -: TAG_W];
    assign a_idx  = addr_q[OFF_W+SUB_W +: IDX_W];
    assign a_sub  = addr_q[OFF_W +: SUB_W];
    assign sub_oh = SUBS'(1) << a_sub;

    logic             match, empty, sub_hit, evict;
    logic [WAY_W-1:0] match_way, empty_way, lru_way, lfu_way, mix_way;
    logic [WAY_W-1:0] victim, acc_way, old_age;

    always_comb begin
        match     = 1'b0;
        match_way = '0;
        empty     = 1'b0;
        empty_way = '0;
        lru_way   = '0;
        lfu_way   = '0;
        mix_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!match && mask_q[a_idx][WAY_W'(w)] != '0 && tag_q[a_idx][WAY_W'(w)] == a_tag) begin
                match     = 1'b1;
                match_way = WAY_W'(w);
            end
            if (!empty && mask_q[a_idx][WAY_W'(w)] == '0) begin
                empty     = 1'b1;
                empty_way = WAY_W'(w);
            end
            if (age_q[a_idx][WAY_W'(w)] == WAY_W'(WAYS - 1))
                lru_way = WAY_W'(w);
            // strict < keeps the lowest index on equal counts
            if (cnt_q[a_idx][WAY_W'(w)] < cnt_q[a_idx][lfu_way])
                lfu_way = WAY_W'(w);
            if (cnt_q[a_idx][WAY_W'(w)] < cnt_q[a_idx][mix_way] ||
                (cnt_q[a_idx][WAY_W'(w)] == cnt_q[a_idx][mix_way] &&
                 age_q[a_idx][WAY_W'(w)] > age_q[a_idx][mix_way]))
                mix_way = WAY_W'(w);
        end

        if (empty)
            victim = empty_way;
        else begin
            case (mode_q)
                M_LFU:     victim = lfu_way;
                M_LFU_LRU: victim = mix_way;
                default:   victim = lru_way;
            endcase
        end

        sub_hit = match && ((mask_q[a_idx][match_way] & sub_oh) != '0);
        evict   = !match && (mask_q[a_idx][victim] != '0);
        acc_way = match ? match_way : victim;
        old_age = age_q[a_idx][acc_way];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    mask_q[IDX_W'(s)][WAY_W'(w)] <= '0;
                    tag_q[IDX_W'(s)][WAY_W'(w)]  <= '0;
                    cnt_q[IDX_W'(s)][WAY_W'(w)]  <= '0;
                    age_q[IDX_W'(s)][WAY_W'(w)]  <= WAY_W'(w);
                end
            end
        end else if (state_q == S_LOOKUP) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == acc_way)
                    age_q[a_idx][WAY_W'(w)] <= '0;
                else if (age_q[a_idx][WAY_W'(w)] < old_age)
                    age_q[a_idx][WAY_W'(w)] <= age_q[a_idx][WAY_W'(w)] + 1'b1;
            end
            if (match) begin
                mask_q[a_idx][acc_way] <= mask_q[a_idx][acc_way] | sub_oh;
                if (cnt_q[a_idx][acc_way] != CNT_MAX)
                    cnt_q[a_idx][acc_way] <= cnt_q[a_idx][acc_way] + 1'b1;
            end else begin
                mask_q[a_idx][acc_way] <= sub_oh;
                tag_q[a_idx][acc_way]  <= a_tag;
                cnt_q[a_idx][acc_way]  <= CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            mode_q          <= M_LRU;
            addr_q          <= '0;
            resp_hit        <= 1'b0;
            resp_sub_miss   <= 1'b0;
            resp_way        <= '0;
            resp_evict      <= 1'b0;
            resp_evict_tag  <= '0;
            resp_evict_mask <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) begin
                addr_q <= req_addr;
                mode_q <= mode_e'(mode);
            end
            if (state_q == S_LOOKUP) begin
                resp_hit        <= sub_hit;
                resp_sub_miss   <= match && !sub_hit;
                resp_way        <= acc_way;
                resp_evict      <= evict;
                resp_evict_tag  <= evict ? tag_q[a_idx][victim] : '0;
                resp_evict_mask <= evict ? mask_q[a_idx][victim] : '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_RESP;
            S_RESP:   if (resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign req_ready  = resetn && (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);

endmodule

// File: tb/tb_yacc_superblock_tag_ctrl.sv
// Directed bench for yacc_superblock_tag_ctrl: vector table of requests with
// hand-computed responses, plus response-hold and reset-in-RESP sequences.
module tb_yacc_superblock_tag_ctrl;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  mode = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_hit, resp_sub_miss, resp_evict;
    logic [1:0]  resp_way;
    logic [20:0] resp_evict_tag;
    logic [3:0]  resp_evict_mask;

    int tests = 0;
    int fails = 0;

    yacc_superblock_tag_ctrl #(
        .ADDR_W(32), .OFF_W(6), .SUB_W(2), .IDX_W(3), .WAYS(4), .CNT_W(3)
    ) dut (
        .clock(clock), .resetn(resetn), .mode(mode),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_sub_miss(resp_sub_miss), .resp_way(resp_way),
        .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
        .resp_evict_mask(resp_evict_mask)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        logic [31:0] addr;
        logic [1:0]  mode;
        logic [29:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk(int unsigned tag, int unsigned idx, int unsigned sub);
        return (tag << 11) | (idx << 8) | (sub << 6);
    endfunction

    // Packed response: {hit, sub_miss, way[1:0], evict, evict_tag[20:0], evict_mask[3:0]}
    function automatic logic [29:0] ex(bit h, bit sm, int unsigned way, bit ev,
                                       int unsigned etag, int unsigned emask);
        return {h, sm, way[1:0], ev, etag[20:0], emask[3:0]};
    endfunction

    function automatic logic [29:0] rsp();
        return {resp_hit, resp_sub_miss, resp_way, resp_evict, resp_evict_tag, resp_evict_mask};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input logic [31:0] a, input logic [1:0] m, input logic [29:0] e);
        vecs.push_back('{rst, a, m, e});
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    // Starts at a negedge; leaves the response held (resp_ready low) at a negedge.
    task automatic do_req(input logic [31:0] a, input logic [1:0] m,
                          output logic [29:0] r, output bit got);
        req_addr  = a;
        mode      = m;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        for (int n = 0; n < 10 && !resp_valid; n++) @(negedge clock);
        got = resp_valid;
        r   = rsp();
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    // Leaves ways 2 and 3 at count 2 with way 3 older, then misses with final mode.
    task automatic add_t5(input logic [1:0] fm, input int unsigned vway, input int unsigned etag);
        add(1'b1, mk(1, 0, 0), 2'd1, ex(0, 0, 0, 0, 0, 0));
        add(1'b0, mk(2, 0, 0), 2'd1, ex(0, 0, 1, 0, 0, 0));
        add(1'b0, mk(3, 0, 0), 2'd1, ex(0, 0, 2, 0, 0, 0));
        add(1'b0, mk(4, 0, 0), 2'd1, ex(0, 0, 3, 0, 0, 0));
        add(1'b0, mk(4, 0, 0), 2'd1, ex(1, 0, 3, 0, 0, 0));
        add(1'b0, mk(3, 0, 0), 2'd1, ex(1, 0, 2, 0, 0, 0));
        add(1'b0, mk(1, 0, 0), 2'd1, ex(1, 0, 0, 0, 0, 0));
        add(1'b0, mk(1, 0, 0), 2'd1, ex(1, 0, 0, 0, 0, 0));
        add(1'b0, mk(2, 0, 0), 2'd1, ex(1, 0, 1, 0, 0, 0));
        add(1'b0, mk(2, 0, 0), 2'd1, ex(1, 0, 1, 0, 0, 0));
        add(1'b0, mk(5, 0, 0), fm,   ex(0, 0, vway, 1, etag, 1));
    endtask

    initial begin
        logic [29:0] r, held;
        bit          got;

        // Sub-block fill, hit, and set isolation
        add(1'b1, 32'h0000_0040, 2'd0, ex(0, 0, 0, 0, 0, 0));
        add(1'b0, 32'h0000_0040, 2'd0, ex(1, 0, 0, 0, 0, 0));
        add(1'b0, 32'h0000_0000, 2'd0, ex(0, 1, 0, 0, 0, 0));
        add(1'b0, 32'h0000_0000, 2'd0, ex(1, 0, 0, 0, 0, 0));
        add(1'b0, 32'h0000_0140, 2'd0, ex(0, 0, 0, 0, 0, 0));
        add(1'b0, 32'h0000_0040, 2'd0, ex(1, 0, 0, 0, 0, 0));
        // LRU fill and eviction
        add(1'b1, mk(1, 0, 0), 2'd0, ex(0, 0, 0, 0, 0, 0));
        add(1'b0, mk(2, 0, 0), 2'd0, ex(0, 0, 1, 0, 0, 0));
        add(1'b0, mk(3, 0, 0), 2'd0, ex(0, 0, 2, 0, 0, 0));
        add(1'b0, mk(4, 0, 0), 2'd0, ex(0, 0, 3, 0, 0, 0));
        add(1'b0, mk(5, 0, 0), 2'd0, ex(0, 0, 0, 1, 1, 1));
        add(1'b0, mk(1, 0, 0), 2'd0, ex(0, 0, 1, 1, 2, 1));
        // LFU, counter saturation, and mode 3 as LRU
        add(1'b1, mk(1, 0, 0), 2'd1, ex(0, 0, 0, 0, 0, 0));
        add(1'b0, mk(2, 0, 0), 2'd1, ex(0, 0, 1, 0, 0, 0));
        add(1'b0, mk(3, 0, 0), 2'd1, ex(0, 0, 2, 0, 0, 0));
        add(1'b0, mk(4, 0, 0), 2'd1, ex(0, 0, 3, 0, 0, 0));
        for (int k = 0; k < 3; k++) add(1'b0, mk(1, 0, 0), 2'd1, ex(1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 2; k++) add(1'b0, mk(2, 0, 0), 2'd1, ex(1, 0, 1, 0, 0, 0));
        add(1'b0, mk(3, 0, 0), 2'd1, ex(1, 0, 2, 0, 0, 0));
        add(1'b0, mk(5, 0, 0), 2'd1, ex(0, 0, 3, 1, 4, 1));
        for (int k = 0; k < 4; k++) add(1'b0, mk(1, 0, 0), 2'd1, ex(1, 0, 0, 0, 0, 0));
        add(1'b0, mk(6, 0, 0), 2'd1, ex(0, 0, 3, 1, 5, 1));
        add(1'b0, mk(7, 0, 0), 2'd3, ex(0, 0, 1, 1, 2, 1));
        // LFU tie-break: age vs. lowest index
        add_t5(2'd2, 3, 4);
        add_t5(2'd1, 2, 3);

        // Reset state
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp", {2'b0, rsp()}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            do_req(vecs[i].addr, vecs[i].mode, r, got);
            check($sformatf("vec%0d_valid", i), {31'd0, got}, 32'd1);
            if (got) check($sformatf("vec%0d", i), {2'b0, r}, {2'b0, vecs[i].exp});
            release_resp();
        end

        // Response held with resp_ready low, then reset while in RESP
        do_reset();
        do_req(32'h0000_0040, 2'd0, held, got);
        check("hold_valid", {31'd0, got}, 32'd1);
        check("hold_first", {2'b0, held}, {2'b0, ex(0, 0, 0, 0, 0, 0)});
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check($sformatf("hold%0d_state", c), {30'd0, resp_valid, req_ready}, 32'd2);
            check($sformatf("hold%0d_resp", c), {2'b0, rsp()}, {2'b0, held});
        end
        #3;
        resetn = 1'b0;
        #1;
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        check("midrst_resp", {2'b0, rsp()}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        do_req(32'h0000_0040, 2'd0, r, got);
        check("postrst_valid", {31'd0, got}, 32'd1);
        check("postrst_miss", {2'b0, r}, {2'b0, ex(0, 0, 0, 0, 0, 0)});
        release_resp();
        check("postrst_idle", {31'd0, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
